// File: rtl/carregador_prog_pit_if.sv
// -----------------------------------------------------------------------------
// carregador_prog_pit_if
// Byte-stream valid/ready channel feeding the program loader.
//   in_valid  master -> slave   stream byte valid
//   in_data   master -> slave   stream byte (held while valid && !ready)
//   in_ready  slave  -> master  loader accepts in_data on this cycle's edge
// Parameter DATA_W sets the stream byte width.
// -----------------------------------------------------------------------------
interface carregador_prog_pit_if #(
   parameter int DATA_W = 8
);
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;

   modport master (output in_valid, output in_data, input in_ready);
   modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/carregador_prog_pit.sv
// -----------------------------------------------------------------------------
// carregador_prog_pit
// Program loader for the simpleton processor. Receives a framed byte stream
// (length, payload, optional checksum), writes the payload into program memory
// while holding the CPU in reset, and releases the CPU only after a complete,
// verified load.
//
// Optional feature macro: CARREGADOR_CHECKSUM_EN
//   defined   : frame = L, payload, checksum byte (8-bit sum of payload)
//   undefined : frame = L, payload; no checksum state or accumulator
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   start      one-cycle pulse, begins a load (honoured in IDLE, RUN, ERR)
//   strm       stream channel (slave side): in_valid, in_data, in_ready
//   mem_write  program-memory write strobe, one cycle per payload byte
//   mem_addr   write address
//   mem_din    write data
//   cpu_hold   CPU reset; 1 = CPU held
//   busy       load in progress (LEN, DATA, CSUM, FLUSH)
//   done       load finished OK, CPU running
//   err        load aborted (bad length or checksum)
// -----------------------------------------------------------------------------
module carregador_prog_pit #(
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 8,
   parameter int MAX_LEN   = 128,
   parameter int BASE_ADDR = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   carregador_prog_pit_if.slave strm,
   output logic                 mem_write,
   output logic [ADDR_W-1:0]    mem_addr,
   output logic [DATA_W-1:0]    mem_din,
   output logic                 cpu_hold,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);

   localparam logic [DATA_W-1:0] MAX_L  = DATA_W'(MAX_LEN);
   localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN,
      S_DATA,
      S_CSUM,
      S_FLUSH,
      S_RUN,
      S_ERR
   } state_t;

   state_t             state_q, state_d;
   logic [DATA_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0]  ptr_q, ptr_d;
   logic               in_ready_q, in_ready_d;
   logic               mem_write_q, mem_write_d;
   logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]  mem_din_q, mem_din_d;
   logic               cpu_hold_q, cpu_hold_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               err_q, err_d;
`ifdef CARREGADOR_CHECKSUM_EN
   logic [DATA_W-1:0]  sum_q, sum_d;
`endif

   logic accept;

   // A byte is consumed only when the registered ready meets valid.
   assign accept = strm.in_valid & in_ready_q;

   // Next-state and next-output logic. All outputs are decoded from the
   // next state so they appear registered and stay consistent with the state
   // register. The memory write for an accepted payload byte is issued on the
   // following cycle, which is why FLUSH exists: it lets the last write land
   // before the CPU leaves reset.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      ptr_d       = ptr_q;
      mem_write_d = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_din_d   = mem_din_q;
`ifdef CARREGADOR_CHECKSUM_EN
      sum_d       = sum_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_LEN;
         end
         S_LEN: begin
            if (accept) begin
               if ((strm.in_data == '0) || (strm.in_data > MAX_L)) begin
                  state_d = S_ERR;
               end else begin
                  cnt_d   = strm.in_data;
                  ptr_d   = BASE_A;
`ifdef CARREGADOR_CHECKSUM_EN
                  sum_d   = '0;
`endif
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (accept) begin
               mem_write_d = 1'b1;
               mem_addr_d  = ptr_q;
               mem_din_d   = strm.in_data;
               ptr_d       = ptr_q + ADDR_W'(1);
               cnt_d       = cnt_q - DATA_W'(1);
`ifdef CARREGADOR_CHECKSUM_EN
               sum_d       = sum_q + strm.in_data;
               if (cnt_q == DATA_W'(1)) state_d = S_CSUM;
`else
               if (cnt_q == DATA_W'(1)) state_d = S_FLUSH;
`endif
            end
         end
`ifdef CARREGADOR_CHECKSUM_EN
         S_CSUM: begin
            if (accept) begin
               state_d = (strm.in_data == sum_q) ? S_FLUSH : S_ERR;
            end
         end
`endif
         S_FLUSH: begin
            state_d = S_RUN;
         end
         S_RUN, S_ERR: begin
            if (start) state_d = S_LEN;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      in_ready_d = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_CSUM);
      busy_d     = in_ready_d || (state_d == S_FLUSH);
      cpu_hold_d = (state_d != S_RUN);
      done_d     = (state_d == S_RUN);
      err_d      = (state_d == S_ERR);
   end

   // State and output registers; reset holds the CPU and idles the loader.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         ptr_q       <= '0;
         in_ready_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_din_q   <= '0;
         cpu_hold_q  <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
`ifdef CARREGADOR_CHECKSUM_EN
         sum_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ptr_q       <= ptr_d;
         in_ready_q  <= in_ready_d;
         mem_write_q <= mem_write_d;
         mem_addr_q  <= mem_addr_d;
         mem_din_q   <= mem_din_d;
         cpu_hold_q  <= cpu_hold_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
`ifdef CARREGADOR_CHECKSUM_EN
         sum_q       <= sum_d;
`endif
      end
   end

   assign strm.in_ready = in_ready_q;
   assign mem_write     = mem_write_q;
   assign mem_addr      = mem_addr_q;
   assign mem_din       = mem_din_q;
   assign cpu_hold      = cpu_hold_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign err           = err_q;

endmodule

// File: tb/tb_carregador_prog_pit.sv
// -----------------------------------------------------------------------------
// tb_carregador_prog_pit
// Directed bench for carregador_prog_pit. Two instances share clk/rst:
// dut0 with BASE_ADDR=0 and dut1 with BASE_ADDR=FE (address wrap case).
// Status vectors are packed as {in_ready, mem_write, cpu_hold, busy, done, err}.
// -----------------------------------------------------------------------------
module tb_carregador_prog_pit;

   typedef logic [7:0] bq_t[$];
   typedef int         iq_t[$];

   localparam logic [5:0] ST_RESET = 6'b001000;
   localparam logic [5:0] ST_LEN   = 6'b101100;
   localparam logic [5:0] ST_ERR   = 6'b001001;
   localparam logic [5:0] ST_RUN   = 6'b000010;
`ifdef CARREGADOR_CHECKSUM_EN
   // Checksum accepted after the last write already issued during CSUM.
   localparam logic [5:0] ST_FLUSH = 6'b001100;
`else
   // Last payload write issues during the FLUSH cycle.
   localparam logic [5:0] ST_FLUSH = 6'b011100;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start0 = 1'b0;
   logic start1 = 1'b0;

   logic       mem_write0, cpu_hold0, busy0, done0, err0;
   logic [7:0] mem_addr0, mem_din0;
   logic       mem_write1, cpu_hold1, busy1, done1, err1;
   logic [7:0] mem_addr1, mem_din1;

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;

   logic [7:0] wa0[$], wd0[$], wa1[$], wd1[$];
   int         wc0[$];

   iq_t no_gaps;

   carregador_prog_pit_if #(.DATA_W(8)) if0 ();
   carregador_prog_pit_if #(.DATA_W(8)) if1 ();

   carregador_prog_pit #(.ADDR_W(8), .DATA_W(8), .MAX_LEN(128), .BASE_ADDR(0)) dut0 (
      .clk(clk), .rst(rst), .start(start0), .strm(if0.slave),
      .mem_write(mem_write0), .mem_addr(mem_addr0), .mem_din(mem_din0),
      .cpu_hold(cpu_hold0), .busy(busy0), .done(done0), .err(err0)
   );

   carregador_prog_pit #(.ADDR_W(8), .DATA_W(8), .MAX_LEN(128), .BASE_ADDR(254)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .strm(if1.slave),
      .mem_write(mem_write1), .mem_addr(mem_addr1), .mem_din(mem_din1),
      .cpu_hold(cpu_hold1), .busy(busy1), .done(done1), .err(err1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Memory-write logger, sampled shortly after each rising edge.
   always @(posedge clk) begin
      #2;
      if (mem_write0 === 1'b1) begin
         wa0.push_back(mem_addr0);
         wd0.push_back(mem_din0);
         wc0.push_back(cyc);
      end
      if (mem_write1 === 1'b1) begin
         wa1.push_back(mem_addr1);
         wd1.push_back(mem_din1);
      end
   end

   function automatic logic [5:0] status0();
      return {if0.in_ready, mem_write0, cpu_hold0, busy0, done0, err0};
   endfunction

   function automatic logic [5:0] status1();
      return {if1.in_ready, mem_write1, cpu_hold1, busy1, done1, err1};
   endfunction

   function automatic logic rdy(input int sel);
      return (sel == 0) ? if0.in_ready : if1.in_ready;
   endfunction

   task automatic pulse_start(input int sel);
      if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      start1 = 1'b0;
   endtask

   // Sends one byte after 'gap' idle cycles; optionally pulses start in the gap.
   task automatic send_byte(input int sel, input logic [7:0] b, input int gap, input int start_in_gap);
      int n;
      for (int i = 0; i < gap; i++) begin
         if (start_in_gap != 0 && i == 0) begin
            if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
         end
         @(negedge clk);
         start0 = 1'b0;
         start1 = 1'b0;
      end
      if (sel == 0) begin if0.in_valid = 1'b1; if0.in_data = b; end
      else          begin if1.in_valid = 1'b1; if1.in_data = b; end
      n = 0;
      while (rdy(sel) !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      compared++;
      if (n >= 20) begin
         mismatched++;
         $display("[TB] FAIL handshake_timeout byte=%02h in_ready=%b required=1", b, rdy(sel));
      end
      @(negedge clk);
      if0.in_valid = 1'b0;
      if1.in_valid = 1'b0;
   endtask

   // Sends length, payload and (when enabled) the bench-computed checksum.
   task automatic send_frame(input int sel, input bq_t pay, input iq_t gaps);
      logic [7:0] s;
      s = 8'h00;
      send_byte(sel, 8'(pay.size()), 0, 0);
      for (int i = 0; i < pay.size(); i++) begin
         s = s + pay[i];
         if (gaps.size() > 0) send_byte(sel, pay[i], gaps[i], i % 2 == 0 ? 1 : 0);
         else                 send_byte(sel, pay[i], 0, 0);
      end
`ifdef CARREGADOR_CHECKSUM_EN
      send_byte(sel, s, (gaps.size() > 0) ? 2 : 0, (gaps.size() > 0) ? 1 : 0);
`endif
   endtask

   task automatic test_reset();
      logic [5:0] st;
      repeat (2) @(negedge clk);
      st = status0();
      compared++;
      if (st !== ST_RESET || mem_addr0 !== 8'h00 || mem_din0 !== 8'h00) begin
         mismatched++;
         $display("[TB] FAIL reset_held status=%b addr=%02h din=%02h required status=%b addr=00 din=00", st, mem_addr0, mem_din0, ST_RESET);
      end
      rst = 1'b0;
      @(negedge clk);
      st = status1();
      compared++;
      if (st !== ST_RESET || mem_addr1 !== 8'h00) begin
         mismatched++;
         $display("[TB] FAIL reset_dut1 status=%b addr=%02h required status=%b addr=00", st, mem_addr1, ST_RESET);
      end
      if0.in_valid = 1'b1;
      if0.in_data  = 8'h55;
      repeat (3) @(negedge clk);
      st = status0();
      compared++;
      if (st !== ST_RESET || wa0.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL idle_valid_ignored status=%b writes=%0d required status=%b writes=0", st, wa0.size(), ST_RESET);
      end
      if0.in_valid = 1'b0;
   endtask

   task automatic test_basic_load();
      bq_t pay;
      logic [5:0] st;
      pay = {8'h21, 8'h80, 8'hF0};
      wa0.delete(); wd0.delete(); wc0.delete();
      pulse_start(0);
      send_frame(0, pay, no_gaps);
      st = status0();
      compared++;
      if (st !== ST_FLUSH) begin
         mismatched++;
         $display("[TB] FAIL basic_flush status=%b required=%b", st, ST_FLUSH);
      end
      @(negedge clk);
      st = status0();
      compared++;
      if (st !== ST_RUN) begin
         mismatched++;
         $display("[TB] FAIL basic_run status=%b required=%b", st, ST_RUN);
      end
      compared++;
      if (wa0.size() != 3) begin
         mismatched++;
         $display("[TB] FAIL basic_write_count got=%0d required=3", wa0.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            compared++;
            if (wa0[i] !== 8'(i) || wd0[i] !== pay[i]) begin
               mismatched++;
               $display("[TB] FAIL basic_write%0d addr=%02h data=%02h required addr=%02h data=%02h", i, wa0[i], wd0[i], 8'(i), pay[i]);
            end
         end
         compared++;
         if (wc0[2] - wc0[0] != 2) begin
            mismatched++;
            $display("[TB] FAIL basic_back_to_back span=%0d required=2", wc0[2] - wc0[0]);
         end
      end
   endtask

   task automatic test_bad_length();
      logic [5:0] st;
      wa0.delete(); wd0.delete(); wc0.delete();
      pulse_start(0);
      st = status0();
      compared++;
      if (st !== ST_LEN) begin
         mismatched++;
         $display("[TB] FAIL restart_from_run status=%b required=%b", st, ST_LEN);
      end
      send_byte(0, 8'h00, 0, 0);
      st = status0();
      compared++;
      if (st !== ST_ERR) begin
         mismatched++;
         $display("[TB] FAIL len_zero status=%b required=%b", st, ST_ERR);
      end
      pulse_start(0);
      st = status0();
      compared++;
      if (st !== ST_LEN) begin
         mismatched++;
         $display("[TB] FAIL start_clears_err status=%b required=%b", st, ST_LEN);
      end
      send_byte(0, 8'h81, 0, 0);
      @(negedge clk);
      st = status0();
      compared++;
      if (st !== ST_ERR || wa0.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL len_81 status=%b writes=%0d required status=%b writes=0", st, wa0.size(), ST_ERR);
      end
   endtask

`ifdef CARREGADOR_CHECKSUM_EN
   task automatic test_checksum_bad();
      logic [5:0] st;
      wa0.delete(); wd0.delete(); wc0.delete();
      pulse_start(0);
      send_byte(0, 8'h03, 0, 0);
      send_byte(0, 8'h21, 0, 0);
      send_byte(0, 8'h80, 0, 0);
      send_byte(0, 8'hF0, 0, 0);
      send_byte(0, 8'h90, 0, 0);
      st = status0();
      compared++;
      if (st !== ST_ERR || wa0.size() != 3) begin
         mismatched++;
         $display("[TB] FAIL csum_bad status=%b writes=%0d required status=%b writes=3", st, wa0.size(), ST_ERR);
      end
   endtask
`endif

   task automatic test_max_len();
      bq_t pay;
      logic [5:0] st;
      int bad;
      for (int i = 0; i < 128; i++) pay.push_back(8'(i));
      wa0.delete(); wd0.delete(); wc0.delete();
      pulse_start(0);
      send_frame(0, pay, no_gaps);
      @(negedge clk);
      st = status0();
      compared++;
      if (st !== ST_RUN || wa0.size() != 128) begin
         mismatched++;
         $display("[TB] FAIL max_len status=%b writes=%0d required status=%b writes=128", st, wa0.size(), ST_RUN);
      end
      bad = 0;
      for (int i = 0; i < wa0.size(); i++)
         if (wa0[i] !== 8'(i) || wd0[i] !== 8'(i)) bad++;
      compared++;
      if (bad != 0) begin
         mismatched++;
         $display("[TB] FAIL max_len_contents bad_entries=%0d required=0", bad);
      end
   endtask

   task automatic test_base_wrap();
      bq_t pay;
      logic [7:0] exp_a[3];
      logic [5:0] st;
      pay = {8'h01, 8'h02, 8'h03};
      exp_a = '{8'hFE, 8'hFF, 8'h00};
      wa1.delete(); wd1.delete();
      pulse_start(1);
      send_frame(1, pay, no_gaps);
      st = status1();
      compared++;
      if (st !== ST_FLUSH) begin
         mismatched++;
         $display("[TB] FAIL wrap_flush status=%b required=%b", st, ST_FLUSH);
      end
      @(negedge clk);
      st = status1();
      compared++;
      if (st !== ST_RUN || wa1.size() != 3) begin
         mismatched++;
         $display("[TB] FAIL wrap_run status=%b writes=%0d required status=%b writes=3", st, wa1.size(), ST_RUN);
      end else begin
         for (int i = 0; i < 3; i++) begin
            compared++;
            if (wa1[i] !== exp_a[i] || wd1[i] !== pay[i]) begin
               mismatched++;
               $display("[TB] FAIL wrap_write%0d addr=%02h data=%02h required addr=%02h data=%02h", i, wa1[i], wd1[i], exp_a[i], pay[i]);
            end
         end
      end
   endtask

   task automatic test_gaps_start();
      bq_t pay;
      iq_t gaps;
      logic [5:0] st;
      pay  = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      gaps = {2, 0, 3, 1, 2};
      wa0.delete(); wd0.delete(); wc0.delete();
      pulse_start(0);
      send_frame(0, pay, gaps);
      @(negedge clk);
      st = status0();
      compared++;
      if (st !== ST_RUN || wa0.size() != 5) begin
         mismatched++;
         $display("[TB] FAIL gaps_run status=%b writes=%0d required status=%b writes=5", st, wa0.size(), ST_RUN);
      end else begin
         for (int i = 0; i < 5; i++) begin
            compared++;
            if (wa0[i] !== 8'(i) || wd0[i] !== pay[i]) begin
               mismatched++;
               $display("[TB] FAIL gaps_write%0d addr=%02h data=%02h required addr=%02h data=%02h", i, wa0[i], wd0[i], 8'(i), pay[i]);
            end
         end
      end
   endtask

   task automatic test_reset_mid_load();
      bq_t pay;
      logic [5:0] st;
      wa0.delete(); wd0.delete(); wc0.delete();
      pulse_start(0);
      send_byte(0, 8'h03, 0, 0);
      send_byte(0, 8'hAA, 0, 0);
      send_byte(0, 8'hBB, 0, 0);
      rst = 1'b1;
      #1;
      st = status0();
      compared++;
      if (st !== ST_RESET || mem_addr0 !== 8'h00 || mem_din0 !== 8'h00) begin
         mismatched++;
         $display("[TB] FAIL mid_reset status=%b addr=%02h din=%02h required status=%b addr=00 din=00", st, mem_addr0, mem_din0, ST_RESET);
      end
      @(negedge clk);
      rst = 1'b0;
      compared++;
      if (wa0.size() != 2) begin
         mismatched++;
         $display("[TB] FAIL mid_reset_writes got=%0d required=2", wa0.size());
      end
      wa0.delete(); wd0.delete(); wc0.delete();
      @(negedge clk);
      pay = {8'h5A, 8'hA5};
      pulse_start(0);
      send_frame(0, pay, no_gaps);
      @(negedge clk);
      st = status0();
      compared++;
      if (st !== ST_RUN || wa0.size() != 2) begin
         mismatched++;
         $display("[TB] FAIL reload_run status=%b writes=%0d required status=%b writes=2", st, wa0.size(), ST_RUN);
      end else begin
         compared++;
         if (wa0[0] !== 8'h00 || wd0[0] !== 8'h5A || wa0[1] !== 8'h01 || wd0[1] !== 8'hA5) begin
            mismatched++;
            $display("[TB] FAIL reload_writes got %02h=%02h %02h=%02h required 00=5A 01=A5", wa0[0], wd0[0], wa0[1], wd0[1]);
         end
      end
   endtask

   initial begin
      if0.in_valid = 1'b0;
      if0.in_data  = 8'h00;
      if1.in_valid = 1'b0;
      if1.in_data  = 8'h00;
      test_reset();
      test_basic_load();
      test_bad_length();
`ifdef CARREGADOR_CHECKSUM_EN
      test_checksum_bad();
`endif
      test_max_len();
      test_base_wrap();
      test_gaps_start();
      test_reset_mid_load();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
